// File: rtl/bus_loader_pkg.sv
// Shared definitions for the UART-driven bus loader: command and response
// codes, FSM state encoding, datapath widths and the length decode helper.
package bus_loader_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 9;

  localparam logic [DATA_W-1:0] CMD_WRITE = 8'h57;
  localparam logic [DATA_W-1:0] CMD_READ  = 8'h52;
  localparam logic [DATA_W-1:0] CMD_PING  = 8'h50;
  localparam logic [DATA_W-1:0] RSP_ACK   = 8'h06;
  localparam logic [DATA_W-1:0] RSP_NAK   = 8'h15;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    ADDR_H = 4'd1,
    ADDR_L = 4'd2,
    LEN    = 4'd3,
    WDATA  = 4'd4,
    WBUS   = 4'd5,
    RBUS   = 4'd6,
    RCAPT  = 4'd7,
    RSEND  = 4'd8,
    RESP   = 4'd9
  } state_e;

  // A length byte of zero stands for a full 256-byte transfer.
  function automatic logic [CNT_W-1:0] len_to_count(input logic [DATA_W-1:0] len);
    return {(len == 8'd0), len};
  endfunction

endpackage

// File: rtl/bus_loader_if.sv
// Bundle of the loader's UART byte streams and memory-bus signals.
//   rx_*   : byte stream from the UART receiver (valid/ready)
//   tx_*   : response byte stream to the UART transmitter (valid/ready)
//   bus_*  : mastership request/grant, address, write data, direction, read data
// master = the loader, slave = UART + bus environment.
interface bus_loader_if;
  import bus_loader_pkg::*;

  logic [DATA_W-1:0] rx_data_i;
  logic              rx_valid_i;
  logic              rx_ready_o;
  logic [DATA_W-1:0] tx_data_o;
  logic              tx_valid_o;
  logic              tx_ready_i;
  logic              bus_req_o;
  logic              bus_gnt_i;
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] data_o;
  logic              R_W_n_o;
  logic [DATA_W-1:0] data_i;

  modport master (
    input  rx_data_i, rx_valid_i, tx_ready_i, bus_gnt_i, data_i,
    output rx_ready_o, tx_data_o, tx_valid_o, bus_req_o, addr_o, data_o, R_W_n_o
  );

  modport slave (
    output rx_data_i, rx_valid_i, tx_ready_i, bus_gnt_i, data_i,
    input  rx_ready_o, tx_data_o, tx_valid_o, bus_req_o, addr_o, data_o, R_W_n_o
  );

endinterface

// File: rtl/bus_loader_timeout.sv
// Inter-byte timeout for partially received commands.
//   clk_i/rst_i : clock, synchronous active-high reset
//   clear       : restart the idle count (byte accepted, or loader idle)
//   enable      : count this clock as idle
//   expired     : registered; high during the TIMEOUT_CYCLES-th idle clock
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 27000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          expired_q, expired_d;

  // Flag is raised one clock early so the FSM acts on the final idle clock.
  always_comb begin
    cnt_d     = cnt_q;
    expired_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d     = cnt_q + CW'(1);
      expired_d = (cnt_d == CW'(TIMEOUT_CYCLES - 1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/bus_loader.sv
// UART command loader: parses cmd/addr_hi/addr_lo/len frames from the rx byte
// stream and performs bus writes, bus reads (streamed back on tx) or a ping.
//   clk_i/rst_i : clock, synchronous active-high reset
//   lb (master) : rx/tx byte streams and the memory bus
// bus_req_o goes to the system integration, which holds the CPU via Rdy and
// hands the bus mux to this block while bus_gnt_i is high.
module bus_loader
  import bus_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 27000000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  bus_loader_if.master lb
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              is_write_q, is_write_d;
  logic              rx_ready_q, rx_ready_d;
  logic              tx_valid_q, tx_valid_d;
  logic              bus_req_q, bus_req_d;

  logic rx_fire, tx_fire, last_xfer;
  logic tmo_clear, tmo_enable, tmo_expired;

  assign rx_fire    = lb.rx_valid_i & rx_ready_q;
  assign tx_fire    = tx_valid_q & lb.tx_ready_i;
  assign last_xfer  = (count_q == CNT_W'(1));
  assign tmo_enable = (state_q inside {ADDR_H, ADDR_L, LEN, WDATA});
  assign tmo_clear  = rx_fire | (state_q == IDLE);

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expired(tmo_expired)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    tx_data_d  = tx_data_q;
    count_d    = count_q;
    is_write_d = is_write_q;

    unique case (state_q)
      IDLE: begin
        if (rx_fire) begin
          unique case (lb.rx_data_i)
            CMD_WRITE: begin is_write_d = 1'b1; state_d = ADDR_H; end
            CMD_READ:  begin is_write_d = 1'b0; state_d = ADDR_H; end
            CMD_PING:  begin tx_data_d = RSP_ACK; state_d = RESP; end
            default:   begin tx_data_d = RSP_NAK; state_d = RESP; end
          endcase
        end
      end
      ADDR_H: begin
        if (rx_fire) begin
          addr_d[ADDR_W-1:8] = lb.rx_data_i;
          state_d            = ADDR_L;
        end else if (tmo_expired) begin
          tx_data_d = RSP_NAK;
          state_d   = RESP;
        end
      end
      ADDR_L: begin
        if (rx_fire) begin
          addr_d[7:0] = lb.rx_data_i;
          state_d     = LEN;
        end else if (tmo_expired) begin
          tx_data_d = RSP_NAK;
          state_d   = RESP;
        end
      end
      LEN: begin
        if (rx_fire) begin
          count_d = len_to_count(lb.rx_data_i);
          state_d = is_write_q ? WDATA : RBUS;
        end else if (tmo_expired) begin
          tx_data_d = RSP_NAK;
          state_d   = RESP;
        end
      end
      WDATA: begin
        if (rx_fire) begin
          data_d  = lb.rx_data_i;
          state_d = WBUS;
        end else if (tmo_expired) begin
          tx_data_d = RSP_NAK;
          state_d   = RESP;
        end
      end
      WBUS: begin
        if (lb.bus_gnt_i) begin
          addr_d  = addr_q + ADDR_W'(1);
          count_d = count_q - CNT_W'(1);
          if (last_xfer) begin
            tx_data_d = RSP_ACK;
            state_d   = RESP;
          end else begin
            state_d = WDATA;
          end
        end
      end
      RBUS: begin
        if (lb.bus_gnt_i) state_d = RCAPT;
      end
      RCAPT: begin
        tx_data_d = lb.data_i;
        state_d   = RSEND;
      end
      RSEND: begin
        if (tx_fire) begin
          addr_d  = addr_q + ADDR_W'(1);
          count_d = count_q - CNT_W'(1);
          state_d = last_xfer ? IDLE : RBUS;
        end
      end
      RESP: begin
        if (tx_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rx_ready_d = (state_d inside {IDLE, ADDR_H, ADDR_L, LEN, WDATA});
    tx_valid_d = (state_d inside {RSEND, RESP});
    bus_req_d  = (state_d inside {WBUS, RBUS});
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      tx_data_q  <= '0;
      count_q    <= '0;
      is_write_q <= 1'b0;
      rx_ready_q <= 1'b1;
      tx_valid_q <= 1'b0;
      bus_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tx_data_q  <= tx_data_d;
      count_q    <= count_d;
      is_write_q <= is_write_d;
      rx_ready_q <= rx_ready_d;
      tx_valid_q <= tx_valid_d;
      bus_req_q  <= bus_req_d;
    end
  end

  assign lb.rx_ready_o = rx_ready_q;
  assign lb.tx_valid_o = tx_valid_q;
  assign lb.tx_data_o  = tx_data_q;
  assign lb.bus_req_o  = bus_req_q;
  assign lb.addr_o     = addr_q;
  assign lb.data_o     = data_q;
  // The write strobe must coincide with the grant cycle itself, so it is
  // gated directly by bus_gnt_i; reset suppresses any write on its edge.
  assign lb.R_W_n_o    = ~((state_q == WBUS) & lb.bus_gnt_i & ~rst_i);

endmodule

// File: doc/bus_loader.md
BUS_LOADER -- requirements
Module: bus_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 27000000, meaning the maximum number of idle clocks allowed between received bytes of one command (1 s at 27 MHz).
REQ-002 SHALL have port clk_i  input  1  system clock; the only clock; all logic is rising-edge.
REQ-003 SHALL have port rst_i  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port rx_data_i  input  8  byte from the UART receiver.
REQ-005 SHALL have port rx_valid_i  input  1  rx_data_i is valid.
REQ-006 SHALL have port rx_ready_o  output  1  the block accepts rx_data_i this cycle.
REQ-007 SHALL have port tx_data_o  output  8  response byte to the UART transmitter.
REQ-008 SHALL have port tx_valid_o  output  1  tx_data_o is valid.
REQ-009 SHALL have port tx_ready_i  input  1  the transmitter accepts tx_data_o this cycle.
REQ-010 SHALL have port bus_req_o  output  1  request for bus mastership; while granted, the CPU is held via Rdy.
REQ-011 SHALL have port bus_gnt_i  input  1  bus granted this cycle.
REQ-012 SHALL have port addr_o  output  16  bus address.
REQ-013 SHALL have port data_o  output  8  bus write data.
REQ-014 SHALL have port R_W_n_o  output  1  bus direction; 1 = read, 0 = write.
REQ-015 SHALL have port data_i  input  8  bus read data; valid one clock after the address is presented (synchronous block RAM).

Function
REQ-016 Handshakes: a byte SHALL transfer on a clock where valid and ready are both 1; tx_data_o SHALL stay stable while tx_valid_o=1 and tx_ready_i=0.
REQ-017 Command format SHALL be: cmd, addr_hi, addr_lo, len, with len 0 meaning 256 bytes.
REQ-018 Command bytes SHALL be: 0x57 'W' write, 0x52 'R' read, 0x50 'P' ping.
REQ-019 'W' SHALL be followed by len data bytes on the rx stream.
REQ-020 FSM states SHALL be: IDLE, ADDR_H, ADDR_L, LEN, WDATA, WBUS, RBUS, RCAPT, RSEND, RESP.
REQ-021 IDLE: on accepting 0x57 or 0x52, SHALL go to ADDR_H; on 0x50, SHALL go to RESP with 0x06; on any other byte, SHALL go to RESP with 0x15 (NAK).
REQ-022 ADDR_H, ADDR_L and LEN SHALL each accept one byte and advance; LEN goes to WDATA for 'W' or RBUS for 'R'.
REQ-023 WDATA SHALL accept one byte into a data register, then go to WBUS.
REQ-024 WBUS SHALL assert bus_req_o; on the first cycle with bus_gnt_i=1 it SHALL drive R_W_n_o=0 for exactly that cycle, then increment the address and decrement the count.
REQ-025 After WBUS, the FSM SHALL return to WDATA, or go to RESP with 0x06 when the count is exhausted.
REQ-026 RBUS SHALL assert bus_req_o with R_W_n_o=1; on the granted cycle it SHALL go to RCAPT.
REQ-027 RCAPT SHALL latch data_i and go to RSEND.
REQ-028 RSEND SHALL present the latched byte; on acceptance it SHALL increment the address and go to RBUS, or to IDLE after the last byte; no trailing ACK is sent for reads.
REQ-029 RESP SHALL present the response byte and return to IDLE on acceptance.
REQ-030 rx_ready_o SHALL be 1 only in IDLE, ADDR_H, ADDR_L, LEN and WDATA.
REQ-031 tx_valid_o SHALL be 1 only in RSEND and RESP.
REQ-032 bus_req_o SHALL be 1 only in WBUS and RBUS; R_W_n_o SHALL be 1 outside the granted write cycle.
REQ-033 Address arithmetic SHALL be 16-bit modulo, so 0xFFFF+1 wraps to 0x0000.
REQ-034 The count SHALL be 9 bits so that len=0 yields 256 transfers.
REQ-035 Timeout: in ADDR_H, ADDR_L, LEN or WDATA, a counter SHALL count clocks without an accepted byte; on reaching TIMEOUT_CYCLES the FSM SHALL go to RESP with 0x15 and discard the partial command. The counter SHALL clear on every accepted byte and in IDLE.
REQ-036 Bytes already written before a timeout SHALL remain written; there is no rollback.
REQ-037 If bus_gnt_i is held 0, the FSM SHALL wait indefinitely in WBUS or RBUS; the timeout SHALL NOT apply in bus states.

Reset
REQ-038 When rst_i=1 at a clock edge, the block SHALL go to IDLE and clear the counters.
REQ-039 During and after reset, outputs SHALL be: bus_req_o=0, R_W_n_o=1, tx_valid_o=0, rx_ready_o=1, addr_o=0x0000, data_o=0x00, tx_data_o=0x00.
REQ-040 Reset mid-operation SHALL abort immediately with no further bus cycle and no response byte.

Structure
REQ-041 A shared package SHALL hold the command constants (0x57, 0x52, 0x50), the response constants (0x06, 0x15) and the FSM state encoding.
REQ-042 The timeout counter SHALL be one sub-module, loader_timeout (inputs: clear, enable; output: expired).
REQ-043 The top-level integration SHALL drive CPU Rdy low and mux the bus when bus_gnt_i=1.

Verification
REQ-044 Ping: rx 0x50 -> tx 0x06 and no bus activity.
REQ-045 Write: rx 57 12 34 02 AA BB with gnt=1 -> granted writes of 0xAA to 0x1234 and 0xBB to 0x1235, each with R_W_n_o=0 for one cycle, then tx 0x06.
REQ-046 Read wrap: memory [0xFFFF]=0x11, [0x0000]=0x22; rx 52 FF FF 02 -> tx 0x11 then 0x22, with addresses 0xFFFF then 0x0000.
REQ-047 Backpressure and grant: gnt held 0 for 10 cycles, tx_ready_i toggled -> bus_req_o stays 1 until granted, tx_data_o stays stable, and no byte is lost.
REQ-048 Timeout (TIMEOUT_CYCLES=100): rx 57 12 then silence -> tx 0x15 at clock 100 after 0x12 was accepted, then back to IDLE; rx 0x41 -> tx 0x15.
REQ-049 Reset during a 256-byte read -> bus_req_o=0 and tx_valid_o=0 the cycle after the reset edge, and a following ping is answered with 0x06.
